// File: rtl/fetch_pkg.sv
// fetch_pkg: shared encodings, constants and types for the instruction fetch unit
package fetch_pkg;
  localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JALR   = 2'b10;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic {RUN, DRAIN} fetch_state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: registered instruction buffer of {pc, instr} entries with flush
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  fetch_entry_t                 wdata,
  input  logic                         pop,
  input  logic                         flush,
  output fetch_entry_t                 rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd, wr;
  // entry storage needs no reset; only pointers and count define validity
  always_ff @(posedge clk) begin
    if (push) mem[wr] <= wdata;
  end
  // pointer and occupancy tracking; flush discards everything at once
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (push) wr <= (wr == AW'(DEPTH - 1)) ? '0 : wr + AW'(1);
      if (pop) rd <= (rd == AW'(DEPTH - 1)) ? '0 : rd + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign rdata = mem[rd];
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC owner, credit-limited imem requester and redirect handling
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] ImmExt,
  input  logic [31:0] ALUResult,
  output logic        misaligned
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  fetch_state_t state, state_nx;
  fetch_entry_t head;
  logic [31:0] fetch_pc, target;
  logic [31:0] aq [DEPTH];
  logic [AW-1:0] aq_rd, aq_wr;
  logic [CW-1:0] inflight, drop_cnt, drop_nx, count;
  logic accept, redirect, take, push, req_fire, credit, fifo_full, empty;
  assign accept   = instr_valid && instr_ready;
  assign redirect = accept && (PCSrc == PCSRC_BRANCH || PCSrc == PCSRC_JALR);
  assign target   = (PCSrc == PCSRC_JALR) ? (ALUResult & 32'hFFFF_FFFE) : PC + ImmExt;
  assign misaligned = redirect && target[1];
  // a pop in the same cycle frees a slot, which sustains one fetch per cycle
  assign credit   = 32'(inflight) + 32'(count) - 32'(accept) < 32'(DEPTH);
  assign imem_req_valid = !reset && !redirect && credit;
  assign imem_req_addr  = fetch_pc;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign take     = imem_rsp_valid && inflight != '0;
  assign push     = take && state == RUN && !redirect;
  assign instr_valid = !empty;
  assign Instr   = empty ? NOP_INSTR : head.instr;
  assign PC      = empty ? fetch_pc : head.pc;
  assign PCPlus4 = PC + 32'd4;
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(reset), .push(push), .wdata('{pc: aq[aq_rd], instr: imem_rsp_data}),
    .pop(accept), .flush(redirect), .rdata(head), .count(count), .full(fifo_full), .empty(empty)
  );
  // everything still in flight at a redirect is stale, including one responding now
  always_comb begin
    drop_nx  = redirect ? inflight - CW'(take) : (state == DRAIN && take) ? drop_cnt - CW'(1) : drop_cnt;
    state_nx = (drop_nx != '0) ? DRAIN : RUN;
  end
  // fetch state, PC and in-flight bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      drop_cnt <= '0;
      inflight <= '0;
      fetch_pc <= RESET_PC;
      aq_rd    <= '0;
      aq_wr    <= '0;
    end else begin
      state    <= state_nx;
      drop_cnt <= drop_nx;
      inflight <= inflight + CW'(req_fire) - CW'(take);
      fetch_pc <= redirect ? (target & 32'hFFFF_FFFC) : fetch_pc + (req_fire ? 32'd4 : 32'd0);
      if (req_fire) aq_wr <= (aq_wr == AW'(DEPTH - 1)) ? '0 : aq_wr + AW'(1);
      if (take) aq_rd <= (aq_rd == AW'(DEPTH - 1)) ? '0 : aq_rd + AW'(1);
    end
  end
  // addresses of outstanding requests, matched to in-order responses
  always_ff @(posedge clk) begin
    if (req_fire) aq[aq_wr] <= fetch_pc;
  end
  // credits guarantee a push into a full buffer always coincides with a pop
  always_ff @(posedge clk) begin
    if (!reset) assert (!(fifo_full && push && !accept));
  end
endmodule
